// File: rtl/serial_paralelo_rx_if.sv
// serial_paralelo_rx_if: serial line in, aligned byte stream out.
// The byte_count signal exists only when SP_RX_BYTE_CNT_EN is defined.
interface serial_paralelo_rx_if;
    logic       in_serial;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
`ifdef SP_RX_BYTE_CNT_EN
    logic [7:0] byte_count;
`endif
    modport master (
        output in_serial,
`ifdef SP_RX_BYTE_CNT_EN
        input  byte_count,
`endif
        input  data_out, valid_out, active
    );
    modport slave (
        input  in_serial,
`ifdef SP_RX_BYTE_CNT_EN
        output byte_count,
`endif
        output data_out, valid_out, active
    );
endinterface

// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: MSB-first deserializer aligning on four COM bytes, dropping COM/IDL once active.
// Optional byte counter enabled by SP_RX_BYTE_CNT_EN.
module serial_paralelo_rx (
    input logic                 clk_32f,
    input logic                 reset,
    serial_paralelo_rx_if.slave bus
);
    localparam logic [7:0] COM        = 8'hBC;
    localparam logic [7:0] IDL        = 8'h7C;
    localparam logic [2:0] COM_TARGET = 3'd4;

    typedef enum logic [1:0] {SEARCH, SYNC, ACTIVE} state_t;

    state_t     state, state_n;
    logic [7:0] sr, data_q, data_n;
    logic [2:0] bit_cnt, bit_n, com_cnt, com_n;
    logic       valid_q, valid_n, active_q, active_n;
    logic       boundary;

    // Once aligned, sr holds a whole byte on the last count of each 8-cycle frame
    assign boundary = bit_cnt == 3'd7;

    always_comb begin
        state_n  = state;
        bit_n    = bit_cnt + 3'd1;
        com_n    = com_cnt;
        data_n   = data_q;
        valid_n  = 1'b0;
        active_n = active_q;
        case (state)
            SEARCH: begin
                bit_n = 3'd0;
                if (sr == COM) begin
                    state_n = SYNC;
                    com_n   = 3'd1;
                end
            end
            SYNC: if (boundary) begin
                if (sr == COM) begin
                    com_n = com_cnt + 3'd1;
                    if (com_n == COM_TARGET) begin
                        state_n  = ACTIVE;
                        active_n = 1'b1;
                    end
                end else begin
                    state_n = SEARCH;
                    com_n   = 3'd0;
                end
            end
            ACTIVE: if (boundary && sr != COM && sr != IDL) begin
                data_n  = sr;
                valid_n = 1'b1;
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state    <= SEARCH;
            sr       <= 8'd0;
            bit_cnt  <= 3'd0;
            com_cnt  <= 3'd0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= {sr[6:0], bus.in_serial};
            bit_cnt  <= bit_n;
            com_cnt  <= com_n;
            data_q   <= data_n;
            valid_q  <= valid_n;
            active_q <= active_n;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = active_q;

`ifdef SP_RX_BYTE_CNT_EN
    logic [7:0] cnt_q;
    always_ff @(posedge clk_32f) begin
        if (reset) cnt_q <= 8'd0;
        else if (valid_n) cnt_q <= cnt_q + 8'd1;
    end
    assign bus.byte_count = cnt_q;
`endif
endmodule
